// File: rtl/clk_ratio_ctrl.sv
// clk_ratio_ctrl: clock-enable generator with boundary-aligned ratio updates and glitch-free start/stop
module clk_ratio_ctrl #(
    parameter int CNT_W         = 6,
    parameter int DEFAULT_RATIO = 5
) (
    input  logic             original_clock,
    input  logic             reset_in,
    input  logic             run_en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_ratio,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             ce_1x,
    output logic             ce_slow,
    output logic             slow_phase,
    output logic [CNT_W-1:0] active_ratio,
    output logic             busy
);
    typedef enum logic [1:0] {STOP, RUN, DRAIN} state_t;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    state_t state, state_next;
    logic [CNT_W-1:0] cnt, pend_ratio;
    logic t1x, t1x_next, running, stopping, boundary, accept, ratio_zero;
    assign running    = state != STOP;
    assign boundary   = running && cnt == active_ratio - ONE;
    assign cfg_ready  = !reset_in && !busy && state != DRAIN;
    assign accept     = cfg_valid && cfg_ready;
    assign ratio_zero = cfg_ratio == '0;
    assign stopping   = running && state_next == STOP;
    always_comb begin
        state_next = state;
        if (state == STOP)
            state_next = run_en ? RUN : STOP;
        else if (state == RUN)
            state_next = run_en ? RUN : DRAIN;
        else
            state_next = run_en ? RUN : (boundary && slow_phase) ? STOP : DRAIN;
        t1x_next = (running && !stopping) ? !t1x : 1'b0;
    end
    always_ff @(posedge original_clock) begin
        if (reset_in) begin
            state        <= STOP;
            cnt          <= '0;
            t1x          <= 1'b0;
            ce_1x        <= 1'b0;
            ce_slow      <= 1'b0;
            slow_phase   <= 1'b0;
            cfg_err      <= 1'b0;
            busy         <= 1'b0;
            pend_ratio   <= '0;
            active_ratio <= CNT_W'(DEFAULT_RATIO);
        end else begin
            state   <= state_next;
            t1x     <= t1x_next;
            ce_1x   <= t1x_next && !t1x;
            ce_slow <= boundary;
            cfg_err <= accept && ratio_zero;
            cnt     <= (!running || stopping || boundary) ? '0 : cnt + ONE;
            if (boundary)
                slow_phase <= !slow_phase;
            // pending ratio takes effect after this boundary's wrap under the old ratio
            if (boundary && busy) begin
                active_ratio <= pend_ratio;
                busy         <= 1'b0;
            end
            if (accept && !ratio_zero) begin
                if (!running)
                    active_ratio <= cfg_ratio;
                else begin
                    pend_ratio <= cfg_ratio;
                    busy       <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_clk_ratio_ctrl.sv
// tb_clk_ratio_ctrl: directed self-checking bench for clk_ratio_ctrl
module tb_clk_ratio_ctrl;
    logic       clk = 1'b0;
    logic       reset_in = 1'b1;
    logic       run_en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [5:0] cfg_ratio = 6'd0;
    logic       cfg_ready, cfg_err, ce_1x, ce_slow, slow_phase, busy;
    logic [5:0] active_ratio;
    int checks = 0;
    int failures = 0;
    int n, c1x, cslow, adj;
    logic prev;

    clk_ratio_ctrl dut (
        .original_clock(clk),
        .reset_in(reset_in),
        .run_en(run_en),
        .cfg_valid(cfg_valid),
        .cfg_ratio(cfg_ratio),
        .cfg_ready(cfg_ready),
        .cfg_err(cfg_err),
        .ce_1x(ce_1x),
        .ce_slow(ce_slow),
        .slow_phase(slow_phase),
        .active_ratio(active_ratio),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // steps until ce_slow is seen; returns the number of steps taken
    task automatic wait_slow(input int maxn, output int cnt_out);
        cnt_out = 0;
        do begin
            step();
            cnt_out++;
        end while (!ce_slow && cnt_out < maxn);
    endtask

    initial begin
        step();
        step();
        check("rst_ready", cfg_ready, 0);
        check("rst_ratio", active_ratio, 5);
        check("rst_outs", {ce_1x, ce_slow, slow_phase, cfg_err, busy}, 0);
        reset_in = 1'b0;
        run_en = 1'b1;
        #1 check("ready_stop", cfg_ready, 1);
        wait_slow(100, n); check("t1_first", n, 6); check("t1_ph1", slow_phase, 1);
        wait_slow(100, n); check("t1_gap", n, 5); check("t1_ph0", slow_phase, 0);
        c1x = 0; cslow = 0; adj = 0; prev = ce_1x;
        for (int i = 0; i < 10; i++) begin
            step();
            c1x += int'(ce_1x);
            cslow += int'(ce_slow);
            adj += int'(ce_1x && prev);
            prev = ce_1x;
        end
        check("t1_ce1x_cnt", c1x, 5);
        check("t1_ce1x_adj", adj, 0);
        check("t1_slow_cnt", cslow, 2);
        check("t1_ph_win", slow_phase, 0);
        run_en = 1'b0;
        step(); check("t5_drain_ready", cfg_ready, 0);
        step(); step();
        run_en = 1'b1;
        wait_slow(100, n); check("t5_resume", n, 2); check("t5_res_ph", slow_phase, 1);
        wait_slow(100, n); check("t5_res_gap", n, 5);
        run_en = 1'b0;
        wait_slow(100, n); check("t5_d1", n, 5); check("t5_d1_ph", slow_phase, 1);
        wait_slow(100, n); check("t5_d2", n, 5); check("t5_d2_ph", slow_phase, 0);
        c1x = 0; cslow = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            c1x += int'(ce_1x);
            cslow += int'(ce_slow);
        end
        check("t5_stop_slow", cslow, 0);
        check("t5_stop_1x", c1x, 0);
        check("t5_stop_ph", slow_phase, 0);
        check("t5_stop_ready", cfg_ready, 1);
        cfg_valid = 1'b1; cfg_ratio = 6'd3;
        step(); cfg_valid = 1'b0;
        check("t2_ratio", active_ratio, 3);
        check("t2_busy", busy, 0);
        run_en = 1'b1;
        wait_slow(100, n); check("t2_first", n, 4);
        wait_slow(100, n); check("t2_gap1", n, 3);
        wait_slow(100, n); check("t2_gap2", n, 3);
        cfg_valid = 1'b1; cfg_ratio = 6'd5;
        step(); cfg_valid = 1'b0;
        check("pend_busy", busy, 1);
        check("pend_ready", cfg_ready, 0);
        wait_slow(100, n); check("pend_gap", n, 2);
        check("pend_ratio", active_ratio, 5);
        check("pend_clr", busy, 0);
        wait_slow(100, n); check("pend_new_gap", n, 5);
        step();
        cfg_valid = 1'b1; cfg_ratio = 6'd2;
        step(); cfg_valid = 1'b0;
        check("t3_busy", busy, 1);
        check("t3_ready", cfg_ready, 0);
        wait_slow(100, n); check("t3_old_gap", n, 3);
        check("t3_ratio", active_ratio, 2);
        check("t3_busy_clr", busy, 0);
        wait_slow(100, n); check("t3_gap_a", n, 2);
        wait_slow(100, n); check("t3_gap_b", n, 2);
        cfg_valid = 1'b1; cfg_ratio = 6'd0;
        step(); cfg_valid = 1'b0;
        check("t4_err", cfg_err, 1);
        check("t4_ratio", active_ratio, 2);
        check("t4_busy", busy, 0);
        step();
        check("t4_err_clr", cfg_err, 0);
        check("t4_running", ce_slow, 1);
        cfg_valid = 1'b1; cfg_ratio = 6'd7;
        step(); cfg_valid = 1'b0;
        check("t6_busy", busy, 1);
        reset_in = 1'b1; run_en = 1'b0;
        step();
        check("t6_outs", {ce_1x, ce_slow, slow_phase, cfg_err, busy}, 0);
        check("t6_ratio", active_ratio, 5);
        check("t6_ready", cfg_ready, 0);
        reset_in = 1'b0; run_en = 1'b1;
        wait_slow(100, n); check("t6_first", n, 6);
        wait_slow(100, n); check("t6_lost", n, 5);
        reset_in = 1'b1; run_en = 1'b0;
        step(); reset_in = 1'b0;
        cfg_valid = 1'b1; cfg_ratio = 6'd1;
        step(); cfg_valid = 1'b0;
        check("r1_ratio", active_ratio, 1);
        run_en = 1'b1;
        wait_slow(100, n); check("r1_first", n, 2); check("r1_ph", slow_phase, 1);
        step(); check("r1_ce_a", {ce_slow, slow_phase}, 2'b10);
        step(); check("r1_ce_b", {ce_slow, slow_phase}, 2'b11);
        reset_in = 1'b1; run_en = 1'b0;
        step(); reset_in = 1'b0;
        cfg_valid = 1'b1; cfg_ratio = 6'd63;
        step(); cfg_valid = 1'b0;
        check("max_ratio", active_ratio, 63);
        run_en = 1'b1;
        wait_slow(200, n); check("max_first", n, 64);
        wait_slow(200, n); check("max_gap", n, 63);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
